instr_prefetch: RTL and testbench

Parametrised fetch front-end for the next-generation RISC-V core. It replaces the zero-latency instruction array read with a handshaked instruction-memory port that supports several outstanding requests. Fetched words and their PCs are buffered in a DEPTH-entry FIFO, and a single-cycle redirect flushes the front-end and retargets it. The block sits between instruction memory and the decoder; redirect comes from the branch/jump resolution logic.

---
 rtl/instr_prefetch.sv | 217 +++++++++++++++++++++
 tb/tb_instr_prefetch.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// instr_prefetch
//   Fetch front-end: issues word fetches to a handshaked instruction memory with
//   up to MAX_OUTSTANDING requests in flight, buffers returned words with their
//   PCs in a DEPTH-entry FIFO with a registered head, and flushes/retargets on a
//   single-cycle redirect. Stale responses that were in flight at a redirect are
//   counted and silently discarded.
//
//   Optional feature macro: PREFETCH_STATS_EN (adds stat_fetched_o/stat_dropped_o)
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   imem_req_o, imem_addr_o       fetch request / word address (req & gnt = issue)
//   imem_gnt_i                    request accepted this cycle
//   imem_rvalid_i, imem_rdata_i   in-order response from memory
//   redirect_i, redirect_pc_i     flush and restart fetch at redirect_pc_i
//   instr_valid_o, instr_o,
//   instr_pc_o                    FIFO head toward the decoder
//   instr_ready_i                 decoder consumes head (valid & ready = pop)
//   stat_fetched_o                (PREFETCH_STATS_EN) number of pops
//   stat_dropped_o                (PREFETCH_STATS_EN) discarded responses + flushed entries
// -----------------------------------------------------------------------------
module instr_prefetch #(
  parameter int unsigned     XLEN            = 32,
  parameter int unsigned     DEPTH           = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            instr_valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  input  logic            instr_ready_i
`ifdef PREFETCH_STATS_EN
  ,
  output logic [31:0]     stat_fetched_o,
  output logic [31:0]     stat_dropped_o
`endif
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PTR_W = AW + 1;
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned CNT_W = ((PTR_W > OUT_W) ? PTR_W : OUT_W) + 1;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] pc;
  } entry_t;

  // State
  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [OUT_W-1:0] outstanding_q, outstanding_d;
  logic [OUT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             head_valid_q, head_valid_d;
  entry_t           head_q, head_d;
  entry_t           mem_q [DEPTH];

  // Combinational helpers
  logic [PTR_W-1:0] fifo_count;
  logic             fifo_empty;
  logic             fifo_full;
  logic [OUT_W-1:0] live_out;
  logic [CNT_W-1:0] credit_sum;
  logic             issue;
  logic             resp_ok;
  logic             resp_drop;
  logic             push;
  logic             pop;
  entry_t           push_entry;
  logic [XLEN-1:0]  redirect_pc_aligned;

  // Credit check, handshake decode and next-state computation
  always_comb begin
    fifo_count = wptr_q - rptr_q;
    fifo_empty = (wptr_q == rptr_q);
    fifo_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    live_out   = outstanding_q - drop_cnt_q;
    credit_sum = CNT_W'(fifo_count) + CNT_W'(live_out);

    // Reset gating keeps the request low while the block is held in reset.
    imem_req_o = rst_ni && !redirect_i
                 && (credit_sum < CNT_W'(DEPTH))
                 && (outstanding_q < OUT_W'(MAX_OUTSTANDING));

    issue     = imem_req_o & imem_gnt_i;
    // A response with nothing outstanding is a protocol violation; ignore it.
    resp_ok   = imem_rvalid_i & (outstanding_q != '0);
    resp_drop = resp_ok & (redirect_i | (drop_cnt_q != '0));
    pop       = !fifo_empty & instr_ready_i & !redirect_i;
    push      = resp_ok & !resp_drop & (!fifo_full | pop);

    push_entry.data     = imem_rdata_i;
    push_entry.pc       = resp_pc_q;
    redirect_pc_aligned = redirect_pc_i & ~XLEN'(3);

    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    wptr_d        = wptr_q;
    rptr_d        = rptr_q;
    outstanding_d = outstanding_q + OUT_W'(issue) - OUT_W'(resp_ok);
    drop_cnt_d    = drop_cnt_q;
    head_valid_d  = 1'b0;
    head_d        = '0;

    if (redirect_i) begin
      // Everything still in flight becomes stale; a response arriving now is
      // already discarded, so it is not counted again.
      fetch_pc_d = redirect_pc_aligned;
      resp_pc_d  = redirect_pc_aligned;
      wptr_d     = '0;
      rptr_d     = '0;
      drop_cnt_d = outstanding_q - OUT_W'(resp_ok);
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
      if (resp_drop) begin
        drop_cnt_d = drop_cnt_q - OUT_W'(1);
      end
      if (push) begin
        resp_pc_d = resp_pc_q + XLEN'(4);
        wptr_d    = wptr_q + PTR_W'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + PTR_W'(1);
      end
    end

    // Registered head: take the word being written this cycle if it lands in
    // the head slot, otherwise read storage at the new read pointer.
    if (wptr_d != rptr_d) begin
      head_valid_d = 1'b1;
      if (push && (rptr_d == wptr_q)) begin
        head_d = push_entry;
      end else begin
        head_d = mem_q[rptr_d[AW-1:0]];
      end
    end
  end

  // Control and head registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      wptr_q        <= '0;
      rptr_q        <= '0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      head_valid_q  <= 1'b0;
      head_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      head_valid_q  <= head_valid_d;
      head_q        <= head_d;
    end
  end

  // FIFO storage (contents are qualified by the pointers, no reset needed)
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wptr_q[AW-1:0]] <= push_entry;
    end
  end

  assign imem_addr_o   = fetch_pc_q;
  assign instr_valid_o = head_valid_q;
  assign instr_o       = head_q.data;
  assign instr_pc_o    = head_q.pc;

`ifdef PREFETCH_STATS_EN
  logic [31:0] stat_fetched_q;
  logic [31:0] stat_dropped_q;
  logic [31:0] stat_drop_inc;

  // Discarded response plus, on redirect, every entry thrown out of the FIFO
  always_comb begin
    stat_drop_inc = 32'(resp_drop);
    if (redirect_i) begin
      stat_drop_inc = stat_drop_inc + 32'(fifo_count);
    end
  end

  // Free-running wrapping statistics counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_fetched_q <= '0;
      stat_dropped_q <= '0;
    end else begin
      stat_fetched_q <= stat_fetched_q + 32'(pop);
      stat_dropped_q <= stat_dropped_q + stat_drop_inc;
    end
  end

  assign stat_fetched_o = stat_fetched_q;
  assign stat_dropped_o = stat_dropped_q;
`endif

endmodule

// File: tb/tb_instr_prefetch.sv
`timescale 1ns/1ps
// Testbench for instr_prefetch: randomized memory/decoder/redirect stimulus
// checked against a queue-level reference model, plus directed scenarios.
module tb_instr_prefetch;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAXO  = 2;
  localparam logic [31:0] RPC   = 32'h0;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;
`ifdef PREFETCH_STATS_EN
  logic [31:0] stat_fetched_o;
  logic [31:0] stat_dropped_o;
`endif

  instr_prefetch #(
    .XLEN(XLEN), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RPC)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
    .instr_ready_i(instr_ready_i)
`ifdef PREFETCH_STATS_EN
    , .stat_fetched_o(stat_fetched_o), .stat_dropped_o(stat_dropped_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] pc;
    bit          stale;
    int          cyc;
  } req_t;

  // Reference model: in-flight requests, buffered PCs, next fetch address
  req_t        pending[$];
  logic [31:0] fifo[$];
  logic [31:0] m_fetch_pc;
  int          st_fetch;
  int          st_drop;
  int          cyc;

  int checks;
  int errors;

  // Stimulus knobs (percent probabilities)
  int          p_gnt, p_ready, p_rvalid, p_redir;
  bit          force_redir;
  logic [31:0] force_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] rand_pc();
    logic [31:0] r;
    r = $urandom();
    if (r[1:0] == 2'b00) return 32'hFFFF_FFE0 | (r & 32'h0000_001F);
    return r & 32'h0000_FFFF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pending.delete();
    fifo.delete();
    m_fetch_pc = RPC;
    st_fetch   = 0;
    st_drop    = 0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_req"},   32'(imem_req_o),    32'd0);
    chk({tag, "_addr"},  imem_addr_o,        RPC);
    chk({tag, "_valid"}, 32'(instr_valid_o), 32'd0);
    chk({tag, "_instr"}, instr_o,            32'd0);
    chk({tag, "_pc"},    instr_pc_o,         32'd0);
`ifdef PREFETCH_STATS_EN
    chk({tag, "_sfetch"}, stat_fetched_o, 32'd0);
    chk({tag, "_sdrop"},  stat_dropped_o, 32'd0);
`endif
  endtask

  // One clock cycle: drive at negedge, check before posedge, update model at posedge
  task automatic step();
    bit   exp_req;
    int   live;
    req_t e;
    @(negedge clk_i);
    cyc++;
    redirect_i    = force_redir || ($urandom_range(99) < p_redir);
    redirect_pc_i = force_redir ? force_pc : rand_pc();
    force_redir   = 1'b0;
    imem_gnt_i    = ($urandom_range(99) < p_gnt);
    imem_rvalid_i = 1'b0;
    if (pending.size() > 0) begin
      if (pending[0].cyc < cyc && $urandom_range(99) < p_rvalid) imem_rvalid_i = 1'b1;
    end
    imem_rdata_i  = imem_rvalid_i ? mem_word(pending[0].pc) : $urandom();
    instr_ready_i = ($urandom_range(99) < p_ready);

    live = 0;
    foreach (pending[i]) if (!pending[i].stale) live++;
    exp_req = !redirect_i && (fifo.size() + live < DEPTH) && (pending.size() < MAXO);

    #1;
    chk("req",   32'(imem_req_o),    32'(exp_req));
    chk("addr",  imem_addr_o,        m_fetch_pc);
    chk("valid", 32'(instr_valid_o), 32'(fifo.size() != 0));
    if (fifo.size() != 0) begin
      chk("head_pc",    instr_pc_o, fifo[0]);
      chk("head_instr", instr_o,    mem_word(fifo[0]));
    end

    @(posedge clk_i);
    if (redirect_i) begin
      st_drop += fifo.size();
      fifo.delete();
      if (imem_rvalid_i) begin
        e = pending.pop_front();
        st_drop++;
      end
      foreach (pending[i]) pending[i].stale = 1'b1;
      m_fetch_pc = redirect_pc_i & 32'hFFFF_FFFC;
    end else begin
      if (instr_ready_i && fifo.size() > 0) begin
        void'(fifo.pop_front());
        st_fetch++;
      end
      if (imem_rvalid_i) begin
        e = pending.pop_front();
        if (e.stale) st_drop++;
        else         fifo.push_back(e.pc);
      end
      if (exp_req && imem_gnt_i) begin
        pending.push_back('{pc: m_fetch_pc, stale: 1'b0, cyc: cyc});
        m_fetch_pc += 32'd4;
      end
    end
  endtask

  task automatic set_knobs(input int g, input int r, input int v, input int d);
    p_gnt = g; p_ready = r; p_rvalid = v; p_redir = d;
  endtask

  task automatic idle_inputs();
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    instr_ready_i = 1'b0;
  endtask

  initial begin
    logic [31:0] held_addr;
    checks = 0; errors = 0; cyc = 0; force_redir = 1'b0; force_pc = '0;
    set_knobs(0, 0, 0, 0);
    idle_inputs();
    model_reset();

    // Reset state
    rst_ni = 1'b0;
    #12;
    check_reset_values("rst");
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Backpressure from reset: exactly PCs 0..12 buffered, fetch stops at 16
    set_knobs(100, 0, 100, 0);
    repeat (10) step();
    #1;
    chk("bp_req",   32'(imem_req_o),    32'd0);
    chk("bp_addr",  imem_addr_o,        32'h10);
    chk("bp_valid", 32'(instr_valid_o), 32'd1);
    chk("bp_pc",    instr_pc_o,         32'h0);

    // Drain and stream with single-cycle memory
    set_knobs(100, 100, 100, 0);
    step();
    #1;
    chk("drain_pc", instr_pc_o, 32'h4);
    repeat (20) step();

    // Redirect with two requests in flight
    set_knobs(100, 100, 0, 0);
    repeat (3) step();
    force_redir = 1'b1; force_pc = 32'h100;
    step();
    #1;
    chk("redir_valid", 32'(instr_valid_o), 32'd0);
    chk("redir_addr",  imem_addr_o,        32'h100);
    set_knobs(100, 100, 100, 0);
    repeat (10) step();

    // Redirect coincident with response and pop, misaligned target
    force_redir = 1'b1; force_pc = 32'h203;
    step();
    #1;
    chk("mis_valid", 32'(instr_valid_o), 32'd0);
    chk("mis_addr",  imem_addr_o,        32'h200);
    repeat (8) step();

    // Grant stall: address must stay put while req is high
    set_knobs(0, 0, 100, 0);
    repeat (3) step();
    #1;
    held_addr = imem_addr_o;
    repeat (5) begin
      step();
      #1;
      chk("stall_addr", imem_addr_o, held_addr);
    end

    // Randomized traffic with varying rates and occasional redirects
    for (int blk = 0; blk < 12; blk++) begin
      set_knobs($urandom_range(100), $urandom_range(100), $urandom_range(100),
                $urandom_range(10));
      repeat (250) step();
    end

    // Async reset mid-stream with a full FIFO
    set_knobs(100, 0, 100, 0);
    repeat (10) step();
    @(negedge clk_i);
    idle_inputs();
    #2 rst_ni = 1'b0;
    #1;
    check_reset_values("arst");
    model_reset();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    // Restart from RESET_PC then more random traffic
    set_knobs(100, 100, 100, 0);
    repeat (6) step();
    for (int blk = 0; blk < 4; blk++) begin
      set_knobs($urandom_range(20, 100), $urandom_range(100), $urandom_range(20, 100),
                $urandom_range(8));
      repeat (200) step();
    end

`ifdef PREFETCH_STATS_EN
    #1;
    chk("stat_fetched", stat_fetched_o, 32'(st_fetch));
    chk("stat_dropped", stat_dropped_o, 32'(st_drop));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
